// File: rtl/cordic_pipe_engine.sv
// Pipelined CORDIC engine: one micro-rotation per register stage, rotation or
// vectoring selected per sample, no gain compensation, wrap-around arithmetic.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         input handshake (in_ready = !stall, combinational)
//   in_mode                     0 = rotation, 1 = vectoring
//   in_x, in_y, in_z            signed operands, z in radians (LSB = 2^-(WIDTH-2))
//   in_tag                      opaque sideband carried with the sample
//   out_valid / out_ready       output handshake
//   out_x, out_y, out_z         results straight from the last stage registers
//   out_mode, out_tag           mode and tag of the result
module cordic_pipe_engine #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STAGES    = 13,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic                    out_mode,
    output logic [TAG_WIDTH-1:0]    out_tag
);

    localparam int unsigned SHIFT = 32 - WIDTH;

    typedef struct packed {
        logic                 mode;
        logic [TAG_WIDTH-1:0] tag;
        logic [WIDTH-1:0]     x;
        logic [WIDTH-1:0]     y;
        logic [WIDTH-1:0]     z;
    } stage_t;

    // atan(2^-k) * 2^30; beyond k = 10 the angle equals 2^-k to this precision
    function automatic logic [31:0] atan_raw(input int unsigned k);
        logic [31:0] r;
        case (k)
            0:       r = 32'h3243F6A9;
            1:       r = 32'h1DAC6705;
            2:       r = 32'h0FADBAFD;
            3:       r = 32'h07F56EA7;
            4:       r = 32'h03FEAB77;
            5:       r = 32'h01FFD55C;
            6:       r = 32'h00FFFAAB;
            7:       r = 32'h007FFF55;
            8:       r = 32'h003FFFEB;
            9:       r = 32'h001FFFFD;
            10:      r = 32'h00100000;
            default: r = (k <= 23) ? (32'd1 << (30 - k)) : 32'd0;
        endcase
        return r;
    endfunction

    // Angle constant rescaled to the z format with round-half-up
    function automatic logic [WIDTH-1:0] atan_ek(input int unsigned k);
        logic [32:0] sum;
        sum = {1'b0, atan_raw(k)} + (33'd1 << (SHIFT - 1));
        return WIDTH'(sum >> SHIFT);
    endfunction

    logic              stall;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] src_vld;
    stage_t            st  [STAGES];
    stage_t            nxt [STAGES];

    // Whole pipe freezes while the result is held by downstream
    assign stall    = vld[STAGES-1] && !out_ready;
    assign in_ready = !stall;

    // Combinational micro-rotation k feeding stage register k
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic signed [WIDTH-1:0] E_K = atan_ek(k);

        stage_t                  cur;
        logic signed [WIDTH-1:0] x, y, z, xs, ys;
        logic                    dpos;

        if (k == 0) begin : g_first
            assign cur        = {in_mode, in_tag, in_x, in_y, in_z};
            assign src_vld[k] = in_valid;
        end else begin : g_next
            assign cur        = st[k-1];
            assign src_vld[k] = vld[k-1];
        end

        assign x  = $signed(cur.x);
        assign y  = $signed(cur.y);
        assign z  = $signed(cur.z);
        assign xs = x >>> k;
        assign ys = y >>> k;

        // Rotation drives z toward 0, vectoring drives y toward 0
        assign dpos = cur.mode ? y[WIDTH-1] : ~z[WIDTH-1];

        assign nxt[k] = dpos ? {cur.mode, cur.tag, WIDTH'(x - ys), WIDTH'(y + xs), WIDTH'(z - E_K)}
                             : {cur.mode, cur.tag, WIDTH'(x + ys), WIDTH'(y - xs), WIDTH'(z + E_K)};
    end

    // Stage registers: shift one step per cycle unless stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                st[k] <= '0;
            end
        end else if (!stall) begin
            vld <= src_vld;
            for (int k = 0; k < int'(STAGES); k++) begin
                st[k] <= nxt[k];
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out_mode  = st[STAGES-1].mode;
    assign out_tag   = st[STAGES-1].tag;
    assign out_x     = $signed(st[STAGES-1].x);
    assign out_y     = $signed(st[STAGES-1].y);
    assign out_z     = $signed(st[STAGES-1].z);

endmodule

// File: tb/tb_cordic_pipe_engine.sv
// Testbench for cordic_pipe_engine: vector table plus streaming, backpressure
// and reset corner sequences, checked through an in-order scoreboard against a
// real-valued CORDIC reference (gain K included, +/-13 LSB tolerance).
module tb_cordic_pipe_engine;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned STAGES    = 13;
    localparam int unsigned TAG_WIDTH = 4;
    localparam int          TOL       = 13;
    localparam real         ZSCALE    = 16384.0;

    typedef struct {
        logic                 mode;
        logic [TAG_WIDTH-1:0] tag;
        int                   x, y, z;
        int                   ex, ey, ez;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc_cycle;
        bit   chk_lat;
    } sb_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic signed [WIDTH-1:0] in_x, in_y, in_z;
    logic [TAG_WIDTH-1:0]    in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_x, out_y, out_z;
    logic                    out_mode;
    logic [TAG_WIDTH-1:0]    out_tag;

    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    int   n_out    = 0;
    bit   lat_en   = 1'b1;
    vec_t idle_v;
    vec_t tbl [10];

    cordic_pipe_engine #(
        .WIDTH    (WIDTH),
        .STAGES   (STAGES),
        .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_z     (in_z),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_z    (out_z),
        .out_mode (out_mode),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    function automatic real gain();
        real g = 1.0;
        real p = 1.0;
        for (int k = 0; k < int'(STAGES); k++) begin
            g = g * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        return g;
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // Ideal CORDIC result including the uncompensated gain
    function automatic vec_t with_model(input vec_t v);
        real  k  = gain();
        real  xr = real'(v.x);
        real  yr = real'(v.y);
        real  zr = real'(v.z) / ZSCALE;
        vec_t r  = v;
        if (!v.mode) begin
            r.ex = rnd(k * (xr * $cos(zr) - yr * $sin(zr)));
            r.ey = rnd(k * (xr * $sin(zr) + yr * $cos(zr)));
            r.ez = 0;
        end else begin
            r.ex = rnd(k * $sqrt(xr * xr + yr * yr));
            r.ey = 0;
            r.ez = v.z + rnd($atan2(yr, xr) * ZSCALE);
        end
        return r;
    endfunction

    function automatic vec_t gen(input int i);
        vec_t v;
        v.mode = i[0];
        v.tag  = TAG_WIDTH'(i);
        if (!v.mode) begin
            v.x = int'($urandom_range(32'h2000, 0)) - 'h1000;
            v.y = int'($urandom_range(32'h2000, 0)) - 'h1000;
            v.z = int'($urandom_range(32'hA000, 0)) - 'h5000;
        end else begin
            v.x = int'($urandom_range(32'h1C00, 32'h1400));
            v.y = int'($urandom_range(32'h1800, 0)) - 'h0C00;
            v.z = int'($urandom_range(32'h1000, 0)) - 'h0800;
        end
        v.ex = 0;
        v.ey = 0;
        v.ez = 0;
        return with_model(v);
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp);
        int d;
        d = act - exp;
        n_checks++;
        if (d > TOL || d < -TOL) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, TOL);
        end
    endtask

    task automatic check_out();
        sb_t e;
        n_out++;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got tag %0d, expected no output", out_tag);
            return;
        end
        e = sb.pop_front();
        check_tol($sformatf("out_x tag%0d", e.v.tag), int'(out_x), e.v.ex);
        check_tol($sformatf("out_y tag%0d", e.v.tag), int'(out_y), e.v.ey);
        check_tol($sformatf("out_z tag%0d", e.v.tag), int'(out_z), e.v.ez);
        check_eq($sformatf("out_tag tag%0d", e.v.tag), int'(out_tag), int'(e.v.tag));
        check_eq($sformatf("out_mode tag%0d", e.v.tag), int'(out_mode), int'(e.v.mode));
        if (e.chk_lat) begin
            check_eq($sformatf("latency tag%0d", e.v.tag), cycle - e.acc_cycle, int'(STAGES));
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later
    task automatic step(input bit iv, input vec_t v, input bit ordy, output bit acc);
        sb_t e;
        @(negedge clk);
        in_valid  = iv;
        in_mode   = v.mode;
        in_tag    = v.tag;
        in_x      = WIDTH'(v.x);
        in_y      = WIDTH'(v.y);
        in_z      = WIDTH'(v.z);
        out_ready = ordy;
        #1;
        cycle++;
        if (out_valid && out_ready) check_out();
        acc = in_valid && in_ready;
        if (acc) begin
            e.v         = v;
            e.acc_cycle = cycle;
            e.chk_lat   = lat_en;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        bit a;
        for (int n = 0; n < 200 && sb.size() != 0; n++) step(1'b0, idle_v, 1'b1, a);
        check_eq("drain_remaining", sb.size(), 0);
    endtask

    task automatic reset_pulse_and_idle(input string name);
        bit a;
        int n0;
        sb.delete();
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        n0 = n_out;
        for (int n = 0; n < 30; n++) step(1'b0, idle_v, 1'b1, a);
        check_eq({name, "_stale_outputs"}, n_out - n0, 0);
    endtask

    initial begin
        bit   a;
        int   n0;
        int   sent;
        vec_t v;
        logic signed [WIDTH-1:0] snap_x, snap_y, snap_z;
        logic [TAG_WIDTH-1:0]    snap_tag;

        idle_v = '{mode: 1'b0, tag: '0, x: 0, y: 0, z: 0, ex: 0, ey: 0, ez: 0};

        // Vector table: literal expectations for the reference cases, model elsewhere
        tbl[0] = '{mode: 1'b0, tag: 4'd5, x: 'h2000, y: 0, z: 0, ex: 'h34B2, ey: 0, ez: 0};
        tbl[1] = '{mode: 1'b1, tag: 4'd1, x: 'h1000, y: 'h1000, z: 0, ex: 'h2543, ey: 0, ez: 'h3244};
        tbl[2] = '{mode: 1'b0, tag: 4'd2, x: 'h1000, y: 0, z: -'h3244, ex: 'h12A2, ey: -'h12A2, ez: 0};
        tbl[3] = with_model('{mode: 1'b0, tag: 4'd3, x: 'h1000, y: 'h0800, z: 'h2000, ex: 0, ey: 0, ez: 0});
        tbl[4] = with_model('{mode: 1'b0, tag: 4'd4, x: -'h1800, y: 'h0400, z: -'h4000, ex: 0, ey: 0, ez: 0});
        tbl[5] = with_model('{mode: 1'b1, tag: 4'd6, x: 'h1800, y: -'h0C00, z: 'h0100, ex: 0, ey: 0, ez: 0});
        tbl[6] = with_model('{mode: 1'b1, tag: 4'd7, x: 'h0800, y: 'h1800, z: 0, ex: 0, ey: 0, ez: 0});
        tbl[7] = with_model('{mode: 1'b0, tag: 4'd8, x: 0, y: 'h1000, z: 'h6000, ex: 0, ey: 0, ez: 0});
        tbl[8] = with_model('{mode: 1'b1, tag: 4'd9, x: 'h1F00, y: 'h0010, z: -'h1000, ex: 0, ey: 0, ez: 0});
        tbl[9] = with_model('{mode: 1'b0, tag: 4'd10, x: -'h2000, y: -'h2000, z: 'h1000, ex: 0, ey: 0, ez: 0});

        // Reset state, with live-looking inputs and out_ready low
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_x      = 16'sh1234;
        in_y      = 16'sh0567;
        in_z      = 16'sh0089;
        in_tag    = 4'hF;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_in_ready", int'(in_ready), 1);
        check_eq("reset_out_x", int'(out_x), 0);
        check_eq("reset_out_y", int'(out_y), 0);
        check_eq("reset_out_z", int'(out_z), 0);
        check_eq("reset_out_tag", int'(out_tag), 0);
        check_eq("reset_out_mode", int'(out_mode), 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Table vectors back to back; first accept right after reset release
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i], 1'b1, a);
            check_eq($sformatf("table_accept_%0d", i), int'(a), 1);
        end
        drain();

        // Streaming: 20 mixed-mode samples, outputs on consecutive cycles
        n0 = n_out;
        for (int i = 0; i < 20; i++) step(1'b1, gen(i), 1'b1, a);
        drain();
        check_eq("stream_count", n_out - n0, 20);

        // Backpressure with a full pipe
        lat_en = 1'b0;
        n0     = n_out;
        sent   = 0;
        v      = gen(100);
        for (int c = 0; c < int'(STAGES); c++) begin
            step(1'b1, v, 1'b1, a);
            if (a) begin
                sent++;
                v = gen(100 + sent);
            end
        end
        snap_x   = '0;
        snap_y   = '0;
        snap_z   = '0;
        snap_tag = '0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, v, 1'b0, a);
            if (a) begin
                sent++;
                v = gen(100 + sent);
            end
            check_eq($sformatf("bp_in_ready_%0d", c), int'(in_ready), 0);
            check_eq($sformatf("bp_out_valid_%0d", c), int'(out_valid), 1);
            if (c == 0) begin
                snap_x   = out_x;
                snap_y   = out_y;
                snap_z   = out_z;
                snap_tag = out_tag;
            end else begin
                check_eq($sformatf("bp_hold_x_%0d", c), int'(out_x), int'(snap_x));
                check_eq($sformatf("bp_hold_y_%0d", c), int'(out_y), int'(snap_y));
                check_eq($sformatf("bp_hold_z_%0d", c), int'(out_z), int'(snap_z));
                check_eq($sformatf("bp_hold_tag_%0d", c), int'(out_tag), int'(snap_tag));
            end
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b1, v, 1'b1, a);
            if (a) begin
                sent++;
                v = gen(100 + sent);
            end
        end
        lat_en = 1'b1;
        drain();
        check_eq("bp_count", n_out - n0, sent);

        // Reset with 6 samples in flight
        for (int i = 0; i < 6; i++) step(1'b1, gen(200 + i), 1'b1, a);
        rst_n = 1'b0;
        #1;
        check_eq("rst6_out_valid", int'(out_valid), 0);
        check_eq("rst6_in_ready", int'(in_ready), 1);
        reset_pulse_and_idle("rst6");

        // Reset with a full pipe and a valid result on the outputs
        for (int i = 0; i < 15; i++) step(1'b1, gen(300 + i), 1'b1, a);
        check_eq("rstfull_pre_out_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_eq("rstfull_out_valid", int'(out_valid), 0);
        check_eq("rstfull_out_x", int'(out_x), 0);
        check_eq("rstfull_out_z", int'(out_z), 0);
        check_eq("rstfull_out_tag", int'(out_tag), 0);
        check_eq("rstfull_in_ready", int'(in_ready), 1);
        reset_pulse_and_idle("rstfull");

        // Fresh sample after the mid-stream reset
        step(1'b1, tbl[0], 1'b1, a);
        check_eq("post_reset_accept", int'(a), 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
